// File: rtl/uart_rx_wb.sv
// Wishbone-slave UART receiver, 8N1, LSB first.
// Samples rx mid-bit from wb_clk, buffers received bytes in a small FIFO and
// raises irq while unread data is present.
module uart_rx_wb #(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        rx,
  input  logic        wb_cyc,
  input  logic        wb_we,
  input  logic        wb_adr,
  input  logic [31:0] wb_dat,
  output logic [31:0] wb_rdt,
  output logic        wb_ack,
  output logic        irq
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;

  localparam logic [CW-1:0]   CC_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CC_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  // Synchroniser
  logic r_rx_meta, r_rs;

  // Receive FSM state
  state_e        r_state, w_state_d;
  logic [CW-1:0] r_cc, w_cc_d;
  logic [2:0]    r_bc, w_bc_d;
  logic [7:0]    r_shreg, w_shreg_d;
  logic          r_push_pend, w_push_d;
  logic          w_ferr_set;

  // FIFO and flags
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovr, r_ferr;

  logic w_empty, w_full, w_pop, w_push, w_ovr_set, w_wr_stat, w_busy;
  logic w_unused;

  assign w_unused = ^{wb_dat[31:3], wb_dat[0]};

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_rx_meta <= 1'b1;
      r_rs      <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rs      <= r_rx_meta;
    end
  end

  // Receive FSM state register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state     <= StIdle;
      r_cc        <= '0;
      r_bc        <= '0;
      r_shreg     <= '0;
      r_push_pend <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cc        <= w_cc_d;
      r_bc        <= w_bc_d;
      r_shreg     <= w_shreg_d;
      r_push_pend <= w_push_d;
    end
  end

  // Receive FSM next state: mid-bit sampling driven by the cycle counter
  always_comb begin
    w_state_d  = r_state;
    w_cc_d     = r_cc + 1'b1;
    w_bc_d     = r_bc;
    w_shreg_d  = r_shreg;
    w_push_d   = 1'b0;
    w_ferr_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cc_d = '0;
        if (!r_rs) w_state_d = StStart;
      end
      StStart: begin
        if (r_cc == CC_HALF) begin
          w_cc_d = '0;
          if (!r_rs) begin
            w_state_d = StData;
            w_bc_d    = '0;
          end else begin
            w_state_d = StIdle;  // too short to be a start bit
          end
        end
      end
      StData: begin
        if (r_cc == CC_FULL) begin
          w_cc_d    = '0;
          w_shreg_d = {r_rs, r_shreg[7:1]};
          w_bc_d    = r_bc + 3'd1;
          if (r_bc == 3'd7) w_state_d = StStop;
        end
      end
      StStop: begin
        if (r_cc == CC_FULL) begin
          w_cc_d = '0;
          if (r_rs) begin
            w_push_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_ferr_set = 1'b1;
            w_state_d  = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold here until the line returns high so a held-low line is not a start
        w_cc_d = '0;
        if (r_rs) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_MAX);
  assign w_busy    = (r_state != StIdle);
  assign w_pop     = wb_ack & ~wb_we & ~wb_adr & ~w_empty;
  // A pop in the same cycle frees a slot in a full FIFO
  assign w_push    = r_push_pend & (~w_full | w_pop);
  assign w_ovr_set = r_push_pend & w_full & ~w_pop;
  assign w_wr_stat = wb_ack & wb_we & wb_adr;
  assign irq       = ~w_empty;

  // FIFO storage; no reset needed since reads are gated by the count
  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wp] <= r_shreg;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Sticky error flags, write-1-to-clear; a new event wins over a clear
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_wr_stat & wb_dat[2]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_wr_stat & wb_dat[1]));
    end
  end

  // Single-cycle bus acknowledge
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) wb_ack <= 1'b0;
    else        wb_ack <= wb_cyc & ~wb_ack;
  end

  // Read data mux, zero outside the ack cycle
  always_comb begin
    wb_rdt = '0;
    if (wb_ack && !wb_we) begin
      if (wb_adr) begin
        wb_rdt = {28'h0, w_busy, r_ovr, r_ferr, ~w_empty};
      end else if (!w_empty) begin
        wb_rdt = {23'h0, 1'b1, r_mem[r_rp]};
      end
    end
  end

endmodule
